// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants for the up_counter_8 slice
package counter_pkg;

  localparam int WIDTH_DEF      = 8;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int MAX_COUNT      = (1 << WIDTH_DEF) - 1;
  // Wide enough for the full 1..255 debounce range
  localparam int DEB_CNT_W      = 8;

endpackage

// File: rtl/step_debounce.sv
// rtl/step_debounce.sv - STEP synchronizer, debouncer and rising-edge pulse
module step_debounce
  import counter_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic STEP,
  output logic step_pulse
);

  localparam logic [DEB_CNT_W-1:0] LAST_CNT = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync_1;
  logic                 sync_2;
  logic                 db;
  logic                 db_d;
  logic [DEB_CNT_W-1:0] stab_cnt;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      db         <= 1'b0;
      db_d       <= 1'b0;
      stab_cnt   <= '0;
      step_pulse <= 1'b0;
    end else begin
      sync_1 <= STEP;
      sync_2 <= sync_1;
      // Any sample agreeing with db restarts the stability window
      if (sync_2 != db) begin
        if (stab_cnt == LAST_CNT) begin
          db       <= sync_2;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end else begin
        stab_cnt <= '0;
      end
      db_d       <= db;
      step_pulse <= db & ~db_d;
    end
  end

endmodule

// File: rtl/up_counter_8.sv
// rtl/up_counter_8.sv - loadable up counter with free-run enable and debounced step input
module up_counter_8
  import counter_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             STEP,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             ROLL
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic step_pulse;
  logic inc;

  step_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step_debounce (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .STEP      (STEP),
    .step_pulse(step_pulse)
  );

  assign inc = EN | step_pulse;

  // LOAD wins over increment; a step pulse coinciding with LOAD is dropped
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      COUNT <= '0;
      ROLL  <= 1'b0;
    end else begin
      ROLL <= 1'b0;
      if (LOAD) begin
        COUNT <= DIN;
      end else if (inc) begin
        COUNT <= COUNT + 1'b1;
        ROLL  <= (COUNT == ALL_ONES);
      end
    end
  end

  assign TC = (COUNT == ALL_ONES);

endmodule

// File: tb/tb_up_counter_8.sv
// tb/tb_up_counter_8.sv - scoreboard bench for up_counter_8 with directed vectors
module tb_up_counter_8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       EN    = 1'b1;
  logic       STEP  = 1'b1;
  logic       LOAD  = 1'b0;
  logic [7:0] DIN   = 8'd0;
  logic [7:0] COUNT;
  logic       TC;
  logic       ROLL;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       tc;
    logic       roll;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  up_counter_8 #(
    .WIDTH     (8),
    .DEB_CYCLES(4)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .EN   (EN),
    .STEP (STEP),
    .LOAD (LOAD),
    .DIN  (DIN),
    .COUNT(COUNT),
    .TC   (TC),
    .ROLL (ROLL)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected output set per clock, checked on the falling edge
  always @(negedge CLOCK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk({mon_e.tag, " count"}, COUNT, mon_e.count);
      chk({mon_e.tag, " tc"}, {7'd0, TC}, {7'd0, mon_e.tc});
      chk({mon_e.tag, " roll"}, {7'd0, ROLL}, {7'd0, mon_e.roll});
    end
  end

  task automatic cyc(input string tag, input logic rst, input logic en, input logic ld,
                     input logic [7:0] din, input logic stp,
                     input logic [7:0] ecount, input logic eroll);
    exp_t e;
    @(negedge CLOCK);
    #1;
    RESET = rst;
    EN    = en;
    LOAD  = ld;
    DIN   = din;
    STEP  = stp;
    if (!rst) begin
      #1;
      chk({tag, " async count"}, COUNT, 8'd0);
      chk({tag, " async roll"}, {7'd0, ROLL}, 8'd0);
    end
    e.tag   = tag;
    e.count = ecount;
    e.tc    = (ecount == 8'hFF);
    e.roll  = eroll;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RESET = 1'b0;
    #1;
    chk("reset_immediate count", COUNT, 8'd0);
    chk("reset_immediate tc", {7'd0, TC}, 8'd0);

    repeat (3) cyc("reset_held", 1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0);
    repeat (2) cyc("post_release", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

    for (int i = 1; i <= 257; i++)
      cyc("free_run", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'(i % 256), (i == 256));
    cyc("free_hold", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0);

    cyc("load10", 1'b1, 1'b0, 1'b1, 8'd10, 1'b0, 8'd10, 1'b0);
    cyc("load_priority", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0);
    cyc("wrap_after_load", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
    cyc("roll_one_cycle", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    cyc("load_ff", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hFF, 1'b0);
    cyc("load0_at_max", 1'b1, 1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0);
    cyc("no_roll_on_load", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);

    for (int j = 0; j < 20; j++)
      cyc("bounce", 1'b1, 1'b0, 1'b0, 8'd0, ((j % 4) < 2), 8'd0, 1'b0);
    for (int j = 20; j < 30; j++)
      cyc("stable_press", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, (j >= 27) ? 8'd1 : 8'd0, 1'b0);
    for (int j = 0; j < 10; j++)
      cyc("release", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0);

    cyc("load5", 1'b1, 1'b0, 1'b1, 8'd5, 1'b0, 8'd5, 1'b0);
    for (int j = 0; j < 10; j++)
      cyc("coincide", 1'b1, (j == 7), 1'b0, 8'd0, 1'b1, (j >= 7) ? 8'd6 : 8'd5, 1'b0);
    for (int j = 0; j < 8; j++)
      cyc("coincide_release", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd6, 1'b0);

    for (int j = 0; j < 10; j++)
      cyc("load_swallow", 1'b1, 1'b0, (j == 7), 8'd20, 1'b1, (j >= 7) ? 8'd20 : 8'd6, 1'b0);
    for (int j = 0; j < 8; j++)
      cyc("swallow_release", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd20, 1'b0);

    for (int j = 0; j < 3; j++)
      cyc("pre_reset_press", 1'b1, 1'b0, 1'b0, 8'd0, 1'b1, 8'd20, 1'b0);
    repeat (2) cyc("mid_debounce_reset", 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0);
    cyc("reset_step_low", 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    for (int j = 0; j < 15; j++)
      cyc("abandoned_step", 1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
    cyc("alive", 1'b1, 1'b1, 1'b0, 8'd0, 1'b0, 8'd1, 1'b0);

    @(negedge CLOCK);
    @(negedge CLOCK);
    #1;
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_counter_8.md
UP_COUNTER_8 -- requirements
Module: up_counter_8

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, counter width in bits.
REQ-002 SHALL provide parameter: DEB_CYCLES, 4, consecutive stable synchronized samples required to accept a STEP level change (legal range 1..255).
REQ-003 SHALL provide port: CLOCK  input  1  rising-edge system clock.
REQ-004 SHALL provide port: RESET  input  1  asynchronous, active-low reset, driven by the upstream reset-synchronizer output (synchronous deassertion guaranteed upstream).
REQ-005 SHALL provide port: EN  input  1  synchronous free-run enable; increment every cycle while high.
REQ-006 SHALL provide port: STEP  input  1  raw asynchronous pushbutton, active-high, bouncing.
REQ-007 SHALL provide port: LOAD  input  1  synchronous parallel load strobe.
REQ-008 SHALL provide port: DIN  input  WIDTH  load value.
REQ-009 SHALL provide port: COUNT  output  WIDTH  registered count value.
REQ-010 SHALL provide port: TC  output  1  terminal count; high while COUNT == 2^WIDTH-1.
REQ-011 SHALL provide port: ROLL  output  1  registered one-cycle pulse after a wrap from 2^WIDTH-1 to 0.

Function
REQ-012 STEP SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Debounce: SHALL hold a debounced level DB; DB takes the synchronized value only after DEB_CYCLES consecutive cycles with synchronized value != DB; any mismatch break SHALL clear the stability counter.
REQ-014 SHALL generate step_pulse, exactly one cycle, on each DB 0->1 transition; DB 1->0 SHALL produce no pulse.
REQ-015 Latency: with STEP cleanly high from before clock edge k, COUNT SHALL change at edge k+DEB_CYCLES+3; no pulse if STEP bounces low within that window (window restarts).
REQ-016 Update priority per edge: LOAD (COUNT<=DIN) > increment (COUNT<=COUNT+1 mod 2^WIDTH) > hold.
REQ-017 Increment condition SHALL be EN OR step_pulse; coincident EN and step_pulse SHALL increment by exactly 1.
REQ-018 LOAD coincident with an increment condition SHALL load DIN and discard the increment; step_pulse lost in that cycle.
REQ-019 Wrap: increment from 2^WIDTH-1 SHALL yield 0 and assert ROLL in the following cycle only.
REQ-020 ROLL SHALL NOT assert on LOAD, including LOAD of 0 while COUNT == 2^WIDTH-1.
REQ-021 TC SHALL be decoded combinationally from the COUNT register (no added latency); LOAD of 2^WIDTH-1 SHALL raise TC the cycle after the load edge.
REQ-022 EN held continuously SHALL count 0,1,...,255,0,... with ROLL period 256 cycles.

Reset
REQ-023 RESET low SHALL immediately force COUNT=0, ROLL=0 (TC=0 as a consequence), synchronizer flops=0, DB=0, stability counter=0, step_pulse=0.
REQ-024 Reset mid-debounce SHALL abandon the pending step; no pulse results from pre-reset STEP activity.
REQ-025 STEP held high through reset release SHALL be treated as a new press: one increment at edge DEB_CYCLES+3 after release (edge 1 = first edge with RESET high).
REQ-026 No output SHALL change on the first CLOCK edge after RESET release unless EN or LOAD is high at that edge.

Structure
REQ-027 Package counter_pkg SHALL hold WIDTH default, DEB_CYCLES default, MAX_COUNT (2^WIDTH-1), and debounce-counter width constant.
REQ-028 Synchronizer, debounce and edge detect SHALL live in sub-module step_debounce (ports CLOCK, RESET, STEP, step_pulse); counter, TC, ROLL stay in up_counter_8.

Verification
REQ-029 Reset: RESET low with EN=1, STEP=1 -> COUNT=0, TC=0, ROLL=0 immediately, held while low.
REQ-030 Free run: EN=1 from COUNT=0 for 256 cycles -> TC high at COUNT=255, COUNT=0 next, ROLL high exactly one cycle, then COUNT=1.
REQ-031 Debounce, DEB_CYCLES=4: STEP toggles every 2 cycles for 20 cycles then high 10 cycles -> exactly one increment, 7 edges after final stable rise; release -> no increment.
REQ-032 Load priority: COUNT=10, LOAD=1, DIN=8'hFF, EN=1 -> COUNT=255, TC=1, ROLL=0; next EN edge -> COUNT=0, ROLL=1.
REQ-033 Coincidence: EN=1 in the step_pulse cycle at COUNT=5 -> COUNT=6 (not 7).
REQ-034 Reset mid-debounce: STEP high 3 cycles, RESET low 2 cycles, STEP low before release -> COUNT stays 0, no ROLL.
